// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the MIPS pipeline: load-use bubbles, EX-resolved branch flushes,
// and mult/div busy tracking, plus a saturating stall-cycle counter.
module hazard_detection_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MULDIV_LATENCY = 32,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_usesRs,
    input  logic                      id_usesRt,
    input  logic                      id_mdStart,
    input  logic                      id_readsHiLo,
    input  logic                      ex_memRead,
    input  logic [REG_ADDR_WIDTH-1:0] ex_regToWrite,
    input  logic                      ex_branchTaken,
    output logic                      pc_stall,
    output logic                      ifid_stall,
    output logic                      ifid_flush,
    output logic                      idex_bubble,
    output logic                      muldiv_start,
    output logic                      muldiv_busy,
    output logic                      muldiv_done,
    output logic [COUNT_WIDTH-1:0]    stall_cycles
);
    localparam int CNT_W = $clog2(MULDIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 1);

    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_nxt;
    logic             loaduse, mdhaz, stall;

    assign muldiv_busy = (state == MD_BUSY);

    assign loaduse = ex_memRead && (ex_regToWrite != '0) &&
                     ((id_usesRs && (id_rs == ex_regToWrite)) ||
                      (id_usesRt && (id_rt == ex_regToWrite)));
    assign mdhaz   = muldiv_busy && (id_readsHiLo || id_mdStart);
    assign stall   = (loaduse || mdhaz) && !ex_branchTaken;

    // Controls are forced low while reset is held, even though they are combinational.
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        muldiv_start = 1'b0;
        if (rst) begin
            if (ex_branchTaken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                muldiv_start = id_mdStart;
            end
        end
    end

    // A flush never cancels an in-flight busy period: the issued op was non-speculative.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            RUN: begin
                if (muldiv_start) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            cnt         <= '0;
            muldiv_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            muldiv_done <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if (pc_stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Randomized + directed bench for hazard_detection_unit against a cycle-level behavioural model.
module tb_hazard_detection_unit;
    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, ex_regToWrite = '0;
    logic          id_usesRs = 0, id_usesRt = 0, id_mdStart = 0, id_readsHiLo = 0;
    logic          ex_memRead = 0, ex_branchTaken = 0;
    logic          pc_stall, ifid_stall, ifid_flush, idex_bubble;
    logic          muldiv_start, muldiv_busy, muldiv_done;
    logic [CW-1:0] stall_cycles;

    hazard_detection_unit #(.REG_ADDR_WIDTH(AW), .MULDIV_LATENCY(LAT), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_usesRs),
        .id_usesRt(id_usesRt), .id_mdStart(id_mdStart), .id_readsHiLo(id_readsHiLo),
        .ex_memRead(ex_memRead), .ex_regToWrite(ex_regToWrite), .ex_branchTaken(ex_branchTaken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy),
        .muldiv_done(muldiv_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    // Model state: busy cycles still to come, done pulse pending, stall count.
    int busy_rem = 0;
    bit done_m   = 0;
    int sc_m     = 0;

    // Expected {pc_stall, ifid_stall, ifid_flush, idex_bubble, muldiv_start, muldiv_busy, muldiv_done}
    function automatic int model_ctl();
        bit busy, lu, md;
        if (!rst) return 0;
        busy = (busy_rem > 0);
        lu = ex_memRead && (ex_regToWrite != 0) &&
             ((id_usesRs && id_rs == ex_regToWrite) || (id_usesRt && id_rt == ex_regToWrite));
        md = busy && (id_readsHiLo || id_mdStart);
        if (ex_branchTaken) return 'b0011000 | (int'(busy) << 1) | int'(done_m);
        if (lu || md)       return 'b1101000 | (int'(busy) << 1) | int'(done_m);
        return (int'(id_mdStart) << 2) | (int'(busy) << 1) | int'(done_m);
    endfunction

    function automatic int dut_ctl();
        return int'({pc_stall, ifid_stall, ifid_flush, idex_bubble, muldiv_start, muldiv_busy, muldiv_done});
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_now();
        chk("ctl", dut_ctl(), model_ctl());
        chk("stall_cycles", int'(stall_cycles), sc_m);
    endtask

    task automatic model_edge();
        int e;
        e = model_ctl();
        if (!rst) begin
            busy_rem = 0; done_m = 0; sc_m = 0;
            return;
        end
        if (e[6] && sc_m < SAT) sc_m++;
        if (e[2]) begin
            busy_rem = LAT; done_m = 0;
        end else if (busy_rem > 0) begin
            done_m = (busy_rem == 1);
            busy_rem--;
        end else begin
            done_m = 0;
        end
    endtask

    // Inputs are set at the falling edge; compare just after, model advances at the rising edge.
    task automatic step();
        #1 compare_now();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_regToWrite = 0; id_usesRs = 0; id_usesRt = 0;
        id_mdStart = 0; id_readsHiLo = 0; ex_memRead = 0; ex_branchTaken = 0;
    endtask

    task automatic set_loaduse();
        clear_in();
        ex_memRead = 1; ex_regToWrite = 8; id_rs = 8; id_usesRs = 1;
    endtask

    int base;

    initial begin
        // Reset held: everything low even with a load-use pattern on the inputs.
        @(negedge clk);
        set_loaduse();
        id_mdStart = 1;
        #1 chk("reset_ctl", dut_ctl(), 0);
        step();
        chk("reset_sc", int'(stall_cycles), 0);
        rst = 1;

        // Load-use: bubble this cycle, counter 0 -> 1 after the edge.
        set_loaduse();
        #1 chk("lu_ctl", dut_ctl(), 'b1101000);
        step();
        chk("lu_sc", int'(stall_cycles), 1);
        clear_in();
        #1 chk("lu_release", dut_ctl(), 0);
        step();
        set_loaduse(); ex_regToWrite = 0; id_rs = 0;
        #1 chk("lu_r0", dut_ctl(), 0);
        step();
        set_loaduse(); id_usesRs = 0;
        #1 chk("lu_nors", dut_ctl(), 0);
        step();

        // Flush beats stall; counter unchanged.
        set_loaduse(); ex_branchTaken = 1;
        #1 chk("flush_ctl", dut_ctl(), 'b0011000);
        step();
        chk("flush_sc", int'(stall_cycles), 1);
        clear_in(); id_mdStart = 1; ex_branchTaken = 1;
        #1 chk("flush_nostart", int'(muldiv_start), 0);
        step();

        // Mult/div timing with HI/LO reader from cycle 2.
        base = int'(stall_cycles);
        clear_in(); id_mdStart = 1;
        #1 chk("md_c0_start", int'(muldiv_start), 1);
        step();
        clear_in();
        #1 chk("md_c1_busy", int'(muldiv_busy), 1);
        step();
        id_readsHiLo = 1;
        for (int c = 2; c <= 4; c++) begin
            #1 chk("md_hilo_stall", dut_ctl(), 'b1101010);
            step();
        end
        #1 chk("md_c5", dut_ctl(), 'b0000001);
        step();
        clear_in();
        #1 chk("md_c6_nodone", int'(muldiv_done), 0);
        chk("md_sc_plus3", int'(stall_cycles), base + 3);
        step();

        // Back-to-back issue with a flush in cycle 2.
        clear_in(); id_mdStart = 1;
        step();
        for (int c = 1; c <= 4; c++) begin
            ex_branchTaken = (c == 2);
            #1 chk("b2b_hold", int'(muldiv_busy), 1);
            step();
        end
        ex_branchTaken = 0;
        #1 chk("b2b_c5", dut_ctl(), 'b0000101);
        step();
        clear_in();
        for (int c = 6; c <= 9; c++) begin
            #1 chk("b2b_busy2", int'(muldiv_busy), 1);
            step();
        end
        #1 chk("b2b_c10", dut_ctl(), 'b0000001);
        step();

        // Asynchronous reset mid-busy (counter at 2): clears before any edge, no done later.
        id_mdStart = 1;
        step();
        clear_in();
        step();
        rst = 0;
        busy_rem = 0; done_m = 0; sc_m = 0;
        #1 chk("rst_busy", int'(muldiv_busy), 0);
        chk("rst_sc", int'(stall_cycles), 0);
        step();
        rst = 1;
        for (int c = 0; c < 6; c++) begin
            #1 chk("rst_nodone", int'(muldiv_done), 0);
            step();
        end

        // Saturation.
        set_loaduse();
        for (int c = 0; c < 20; c++) step();
        chk("sat_sc", int'(stall_cycles), SAT);
        clear_in();
        step();

        // Randomized traffic; reset occasionally to restart the counter.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 0;
                busy_rem = 0; done_m = 0; sc_m = 0;
            end else begin
                rst = 1;
            end
            id_rs          = AW'($urandom_range(0, 3));
            id_rt          = AW'($urandom_range(0, 3));
            ex_regToWrite  = AW'($urandom_range(0, 3));
            id_usesRs      = ($urandom_range(0, 1) == 1);
            id_usesRt      = ($urandom_range(0, 1) == 1);
            ex_memRead     = ($urandom_range(0, 2) == 0);
            ex_branchTaken = ($urandom_range(0, 6) == 0);
            id_mdStart     = ($urandom_range(0, 4) == 0);
            id_readsHiLo   = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got stuck expected finish");
        $fatal(1);
    end
endmodule
